// File: rtl/output_equalizer_pkg.sv
// Shared types and constants for the histogram-equalization back end.
// Holds the FSM state codes, pixel/CDF widths and default geometry.
package output_equalizer_pkg;

  localparam int PIXELS_PER_WORD = 16;
  localparam int PIX_W = 8;
  localparam int CDF_W = 20;
  localparam int NUM_W = 28;

  localparam int NUM_PIXELS_DEF = 65536;
  localparam int CDF_BASE_0_DEF = 0;
  localparam int CDF_BASE_1_DEF = 256;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_WAIT_CDF = 3'd1;
  localparam state_t S_LUT_RD   = 3'd2;
  localparam state_t S_LUT_DIV  = 3'd3;
  localparam state_t S_LUT_WR   = 3'd4;
  localparam state_t S_IMG      = 3'd5;
  localparam state_t S_DONE     = 3'd6;

  function automatic logic [PIX_W-1:0] sat8(
    input logic [NUM_W-1:0] q
  );
    return (|q[NUM_W-1:PIX_W]) ? 8'hFF : q[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/output_equalizer_seq_divider.sv
// Restoring divider, one quotient bit per cycle.
// done pulses for one cycle once quo holds num/den.
module seq_divider
  import output_equalizer_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [CDF_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  logic [CDF_W-1:0] rem;
  logic [4:0]       cnt;
  logic [CDF_W:0]   shifted;
  logic [CDF_W:0]   trial;

  // trial subtract; a set top bit means the subtraction borrowed
  always_comb begin
    shifted = {rem, quo[NUM_W-1]};
    trial   = shifted - {1'b0, den};
  end

  // shift dividend bits into the remainder, one per cycle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quo  <= num;
      cnt  <= 5'(NUM_W);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      quo <= {quo[NUM_W-2:0], ~trial[CDF_W]};
      rem <= trial[CDF_W] ? shifted[CDF_W-1:0]
                          : trial[CDF_W-1:0];
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/output_equalizer.sv
// Builds the 256-entry intensity map from the CDF in m2, then
// streams m3 through the map into m4, one 16-pixel word per cycle.
module output_equalizer
  import output_equalizer_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int NUM_WORDS  = NUM_PIXELS / PIXELS_PER_WORD,
  parameter int CDF_BASE_0 = CDF_BASE_0_DEF,
  parameter int CDF_BASE_1 = CDF_BASE_1_DEF
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cdf_valid,
  input  logic [19:0]  cdf_min,
  input  logic         inputBaseOffset,
  output logic [15:0]  m2ReadAddr,
  input  logic [35:0]  m2ReadBus,
  output logic [15:0]  m3ReadAddr,
  input  logic [127:0] m3ReadBus,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteBus,
  output logic         m4WE,
  output logic         done
);

  localparam logic [CDF_W-1:0] NP = CDF_W'(NUM_PIXELS);
  localparam logic [16:0] N_RD     = 17'(NUM_WORDS);
  localparam logic [16:0] LAST_RD  = 17'(NUM_WORDS - 1);
  localparam logic [16:0] LAST_CYC = 17'(NUM_WORDS + 1);

  state_t           state;
  logic [PIX_W-1:0] v;
  logic [PIX_W-1:0] map_r;
  logic             div_issued;
  logic [16:0]      img_cnt;
  logic [PIX_W-1:0] lut [256];

  logic [15:0]      base;
  logic [CDF_W-1:0] cdf_v;
  logic [CDF_W-1:0] den;
  logic [CDF_W-1:0] diff;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] quo;
  logic             below;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic             unused_hi;

  logic             rd_v;
  logic             p1_v;
  logic [15:0]      p1_addr;
  logic [127:0]     remap;

  // mapping arithmetic for the bin currently on m2ReadBus
  always_comb begin
    base = inputBaseOffset ? 16'(CDF_BASE_1)
                           : 16'(CDF_BASE_0);
    cdf_v = m2ReadBus[CDF_W-1:0];
    unused_hi = ^m2ReadBus[35:CDF_W];
    den   = NP - cdf_min;
    below = cdf_v < cdf_min;
    diff  = cdf_v - cdf_min;
    num   = {8'b0, diff} * 28'd255
          + {9'b0, den[CDF_W-1:1]};
    div_start = (state == S_LUT_DIV) && !div_issued
             && !below && (den != '0) && !div_busy;
  end

  seq_divider u_div (
    .clock (clock),
    .rst_n (rst_n),
    .start (div_start),
    .num   (num),
    .den   (den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (quo)
  );

  // frame sequencing: CDF wait, per-bin map build, image stream
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      v          <= '0;
      map_r      <= '0;
      div_issued <= 1'b0;
      img_cnt    <= '0;
      m2ReadAddr <= '0;
      m3ReadAddr <= '0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT_CDF;
            done  <= 1'b0;
          end
        end
        S_WAIT_CDF: begin
          if (cdf_valid) begin
            v          <= '0;
            m2ReadAddr <= base;
            state      <= S_LUT_RD;
          end
        end
        S_LUT_RD: begin
          div_issued <= 1'b0;
          state      <= S_LUT_DIV;
        end
        S_LUT_DIV: begin
          if (!div_issued) begin
            if (below) begin
              map_r <= '0;
              state <= S_LUT_WR;
            end else if (den == '0) begin
              map_r <= v;
              state <= S_LUT_WR;
            end else if (div_start) begin
              div_issued <= 1'b1;
            end
          end else if (div_done) begin
            map_r <= sat8(quo);
            state <= S_LUT_WR;
          end
        end
        S_LUT_WR: begin
          if (v == 8'hFF) begin
            img_cnt    <= '0;
            m3ReadAddr <= '0;
            state      <= S_IMG;
          end else begin
            v          <= v + 8'd1;
            m2ReadAddr <= base + {8'b0, v + 8'd1};
            state      <= S_LUT_RD;
          end
        end
        S_IMG: begin
          img_cnt <= img_cnt + 17'd1;
          if (img_cnt < LAST_RD)
            m3ReadAddr <= m3ReadAddr + 16'd1;
          if (img_cnt == LAST_CYC) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            done  <= 1'b0;
            state <= S_WAIT_CDF;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // map storage; contents only matter after a full rebuild
  always_ff @(posedge clock) begin
    if (state == S_LUT_WR)
      lut[v] <= map_r;
  end

  // per-byte lookup of the word returned by m3
  always_comb begin
    remap = '0;
    for (int i = 0; i < PIXELS_PER_WORD; i++)
      remap[i*PIX_W +: PIX_W] = lut[m3ReadBus[i*PIX_W +: PIX_W]];
    rd_v = (state == S_IMG) && (img_cnt < N_RD);
  end

  // two-stage address-to-write pipeline into m4
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      p1_v        <= 1'b0;
      p1_addr     <= '0;
      m4WE        <= 1'b0;
      m4WriteAddr <= '0;
      m4WriteBus  <= '0;
    end else begin
      p1_v    <= rd_v;
      p1_addr <= m3ReadAddr;
      m4WE    <= p1_v;
      if (p1_v) begin
        m4WriteAddr <= p1_addr;
        m4WriteBus  <= remap;
      end
    end
  end

endmodule

// File: tb/tb_output_equalizer.sv
// Directed bench for output_equalizer with m2/m3 models
// and an m4 scoreboard driven by hand-derived pixel maps.
module tb_output_equalizer;

  localparam int NW = 4096;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic         cdf_valid;
  logic [19:0]  cdf_min;
  logic         inputBaseOffset;
  logic [15:0]  m2ReadAddr;
  logic [35:0]  m2ReadBus;
  logic [15:0]  m3ReadAddr;
  logic [127:0] m3ReadBus;
  logic [15:0]  m4WriteAddr;
  logic [127:0] m4WriteBus;
  logic         m4WE;
  logic         done;

  output_equalizer dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .start           (start),
    .cdf_valid       (cdf_valid),
    .cdf_min         (cdf_min),
    .inputBaseOffset (inputBaseOffset),
    .m2ReadAddr      (m2ReadAddr),
    .m2ReadBus       (m2ReadBus),
    .m3ReadAddr      (m3ReadAddr),
    .m3ReadBus       (m3ReadBus),
    .m4WriteAddr     (m4WriteAddr),
    .m4WriteBus      (m4WriteBus),
    .m4WE            (m4WE),
    .done            (done)
  );

  always #5 clock = ~clock;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [35:0] m2 [512];
  logic [35:0] m2_q;
  logic [127:0] m3_q;
  logic [7:0] exp_map [256];
  int img_mode = 0;

  function automatic logic [7:0] pix(int k, int i);
    int r = (k + i) % 3;
    case (img_mode)
      0: return 8'((k * 16 + i) & 255);
      1: return (r == 0) ? 8'd0 : (r == 1) ? 8'd100 : 8'd255;
      2: return (r == 0) ? 8'd10 : (r == 1) ? 8'd20 : 8'd0;
      default: return 8'd7;
    endcase
  endfunction

  function automatic logic [127:0] img_word(int k);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = pix(k, i);
    return w;
  endfunction

  function automatic logic [127:0] exp_word(int k);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = exp_map[pix(k, i)];
    return w;
  endfunction

  always @(posedge clock) begin
    m2_q <= m2[m2ReadAddr[8:0]];
    m3_q <= img_word(int'(m3ReadAddr));
  end
  assign m2ReadBus = m2_q;
  assign m3ReadBus = m3_q;

  logic         sb_clr = 1'b0;
  logic         mon_on = 1'b0;
  int           cyc = 0;
  int           wr_cnt = 0;
  int           wr_err = 0;
  int           first_we = 0;
  int           done_cyc = 0;
  int           backsteps = 0;
  logic [127:0] wr0 = '0;
  logic         done_q = 1'b0;
  logic [15:0]  m2_prev = '0;

  always @(negedge clock) begin
    cyc++;
    if (sb_clr) begin
      wr_cnt = 0;
      wr_err = 0;
      first_we = 0;
      done_cyc = 0;
      wr0 = '0;
    end else if (m4WE) begin
      if (wr_cnt == 0) first_we = cyc;
      if (m4WriteAddr != 16'(wr_cnt) ||
          m4WriteBus != exp_word(wr_cnt))
        wr_err++;
      if (m4WriteAddr == 16'd0) wr0 = m4WriteBus;
      wr_cnt++;
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
    if (mon_on && m2ReadAddr < m2_prev) backsteps++;
    m2_prev = m2ReadAddr;
  end

  task automatic clear_sb();
    @(posedge clock);
    sb_clr = 1'b1;
    @(posedge clock);
    sb_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, 128'(done), 128'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic frame_checks(input string tag,
                              input logic [127:0] w0);
    chk({tag, "_nwr"}, 128'(wr_cnt), 128'(NW));
    chk({tag, "_err"}, 128'(wr_err), 128'd0);
    chk({tag, "_lat"}, 128'(done_cyc - first_we), 128'(NW));
    chk({tag, "_w0"}, wr0, w0);
  endtask

  initial begin
    int n;
    int w_snap;
    rst_n = 1'b0;
    start = 1'b0;
    cdf_valid = 1'b0;
    cdf_min = '0;
    inputBaseOffset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_we", 128'(m4WE), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_addr", 128'({m2ReadAddr, m3ReadAddr, m4WriteAddr}), 128'd0);
    chk("rst_bus", m4WriteBus, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // uniform CDF at base 256, late cdf_valid, ignored restart
    for (int a = 0; a < 512; a++) m2[a] = '0;
    for (int b = 0; b < 256; b++) m2[256 + b] = 36'((b + 1) * 256);
    for (int b = 0; b < 256; b++) exp_map[b] = 8'(b);
    cdf_min = 20'd256;
    inputBaseOffset = 1'b1;
    img_mode = 0;
    clear_sb();
    pulse_start();
    repeat (20) @(negedge clock);
    chk("t1_hold", 128'(m2ReadAddr), 128'd0);
    cdf_valid = 1'b1;
    mon_on = 1'b1;
    n = 0;
    while (m2ReadAddr != 16'd356 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("t1_reach", 128'(m2ReadAddr), 128'd356);
    pulse_start();
    wait_done("t1");
    mon_on = 1'b0;
    chk("t1_back", 128'(backsteps), 128'd0);
    frame_checks("t1", 128'h0F0E0D0C0B0A09080706050403020100);

    // two-level image, junk in the upper CDF bits
    inputBaseOffset = 1'b0;
    for (int b = 0; b < 256; b++)
      m2[b] = {16'hABCD, (b == 255) ? 20'd65536 : 20'd32768};
    cdf_min = 20'd32768;
    img_mode = 1;
    exp_map[0] = 8'h00;
    exp_map[100] = 8'h00;
    exp_map[255] = 8'hFF;
    clear_sb();
    pulse_start();
    wait_done("t2");
    frame_checks("t2", 128'h00FF0000FF0000FF0000FF0000FF0000);

    // pixels 10/20 half and half, bins below min saturate low
    for (int b = 0; b < 256; b++)
      m2[b] = (b < 10) ? 36'd0 : (b < 20) ? 36'd32768 : 36'd65536;
    img_mode = 2;
    exp_map[0] = 8'h00;
    exp_map[10] = 8'h00;
    exp_map[20] = 8'hFF;
    clear_sb();
    pulse_start();
    wait_done("t3");
    frame_checks("t3", 128'h0000FF0000FF0000FF0000FF0000FF00);

    // single-intensity frame, den == 0
    for (int b = 0; b < 256; b++) m2[b] = 36'd65536;
    cdf_min = 20'd65536;
    img_mode = 3;
    for (int b = 0; b < 256; b++) exp_map[b] = 8'(b);
    clear_sb();
    pulse_start();
    wait_done("t4");
    frame_checks("t4", {16{8'h07}});

    // reset during the image stream, then a fresh frame
    img_mode = 0;
    clear_sb();
    pulse_start();
    n = 0;
    while (m3ReadAddr != 16'd1000 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("t5_reach", 128'(m3ReadAddr), 128'd1000);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", 128'(m4WE), 128'd0);
    chk("t5_rst_addr", 128'({m2ReadAddr, m3ReadAddr, m4WriteAddr}), 128'd0);
    chk("t5_rst_bus", m4WriteBus, 128'd0);
    w_snap = wr_cnt;
    repeat (5) @(negedge clock);
    rst_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("t5_no_wr", 128'(wr_cnt - w_snap), 128'd0);
    chk("t5_idle_done", 128'(done), 128'd0);
    clear_sb();
    pulse_start();
    wait_done("t5");
    frame_checks("t5", 128'h0F0E0D0C0B0A09080706050403020100);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/output_equalizer.md
Name: output_equalizer

Overview:
- Back end of the histogram-equalization pipeline, and the reader of the data the input stage writes.
- Input stage writes the raw image into m3; the CDF stage leaves 256 CDF entries in m2.
- This block turns the CDF into a 256-entry intensity map, streams the image back out of m3, remaps every pixel and writes the equalized image into m4.

Parameters:
- NUM_PIXELS, 65536: pixels per frame (256x256); 16 pixels per 128-bit word.
- NUM_WORDS, 4096: NUM_PIXELS/16, image words in m3/m4.
- CDF_BASE_0, 0: m2 word address of CDF bin 0 when inputBaseOffset=0.
- CDF_BASE_1, 256: m2 word address of CDF bin 0 when inputBaseOffset=1.

Ports:
- clock  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle start pulse.
- cdf_valid  input  1  CDF stage finished; cdf_min is stable.
- cdf_min  input  20  smallest nonzero CDF value.
- inputBaseOffset  input  1  selects the CDF base in m2.
- m2ReadAddr  output  16  CDF read address.
- m2ReadBus  input  36  CDF word; CDF value in bits [19:0], upper bits ignored.
- m3ReadAddr  output  16  image read address.
- m3ReadBus  input  128  16 pixels; pixel i in bits [8i+7:8i].
- m4WriteAddr  output  16  output image address.
- m4WriteBus  output  128  16 remapped pixels, same byte order as m3ReadBus.
- m4WE  output  1  write enable.
- done  output  1  frame complete.

Behaviour:
- Memory timing: all reads are synchronous; data is valid the cycle after the address is presented.
- Reset: rst_n low asynchronously forces state IDLE and clears all outputs to 0 (addresses, m4WriteBus, m4WE, done). The LUT contents are don't-care after reset.
- Reset mid-operation aborts the frame; no further m4 writes occur until the next start.
- State IDLE: start -> WAIT_CDF; done is cleared on that same edge.
- State WAIT_CDF: waits for cdf_valid, then v=0 -> LUT_RD. If cdf_valid is already high at start, WAIT_CDF lasts one cycle.
- State LUT_RD: m2ReadAddr = base + v; next cycle latch cdf(v) -> LUT_DIV.
- State LUT_DIV: compute map(v) with a 20-bit den = NUM_PIXELS - cdf_min (NUM_PIXELS itself is not limited to 20 bits):
  - cdf(v) < cdf_min -> map = 0.
  - den == 0 (single-intensity frame) -> map = v.
  - otherwise num = (cdf(v) - cdf_min)*255 + (den>>1) (28 bits), map = min(num/den, 255).
  - The divider takes at most 30 cycles per bin.
- State LUT_WR: LUT[v] = map. If v==255 go to IMG, else v+1 and return to LUT_RD.
- State IMG: streaming, one word per cycle.
  - m3ReadAddr = k for k = 0..NUM_WORDS-1 on consecutive cycles.
  - Two cycles after address k: m4WE=1, m4WriteAddr=k, m4WriteBus byte i = LUT[m3 byte i].
  - Address-to-write latency is 2; the phase lasts NUM_WORDS+2 cycles; m4WE is 0 outside valid writes.
- State DONE: done=1 and held until the next start; m4WE=0; return to IDLE (done still high).
- start while not in IDLE/DONE is ignored.
- The m2 read address is unused (held) outside LUT_RD; m3 likewise outside IMG.

Decomposition:
- Shared package holds:
  - the state enum;
  - PIXELS_PER_WORD=16, PIX_W=8, CDF_W=20;
  - the default NUM_PIXELS and CDF bases.
- One natural sub-module: seq_divider, a 28-by-20-bit restoring divider with start/busy/done handshake.
- The LUT (256x8 flops) and the 2-stage image pipeline stay in the top level.

Test Plan:
- Uniform CDF, cdf(v) = (v+1)*256, cdf_min=256 -> map is identity; m3 word 0x0F0E..0100 is written unchanged to m4 address 0; all 4096 words are written, and done rises NUM_WORDS+2 cycles after the first m3 read.
- Two-level image, cdf(0..254)=32768, cdf(255)=65536, cdf_min=32768 -> pixel 0 maps to 0x00, pixel 255 maps to 0xFF, LUT[100] = 0.
- Pixels 10/20 split half and half, cdf(0..9)=0, cdf(10..19)=32768, cdf(20..255)=65536, cdf_min=32768 -> bins 0..19 map to 0 (cdf below min saturates), bin 20 maps to 255.
- All pixels 7, cdf_min=65536 (den=0) -> identity; word of 0x07 bytes is output unchanged.
- start pulsed with cdf_valid=0 -> no m2 reads until cdf_valid rises; a second start mid-LUT is ignored with no restart of v.
- rst_n asserted during IMG at k=1000 -> all outputs 0 immediately, m4WE stays 0; a fresh start then produces a full correct frame.
